// File: rtl/uart_frame_decoder.sv
// Purpose: decodes SYNC/ADDR/LEN/payload/CHK byte frames into addressed 32-bit words.
// Latency: word, done and error strobes appear one clock after the valid_in cycle that completes them.
// Backpressure: none; every valid_in strobe is consumed, and an idle gap inside a frame ends in a timeout error.
module uart_frame_decoder #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic [7:0]  byte_in,
  output logic        valid_out,
  output logic [15:0] addr_out,
  output logic [31:0] data_out,
  output logic        frame_done_out,
  output logic        frame_error_out,
  output logic        busy_out
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  // The idle counter has counted TIMEOUT_CYCLES-1 idle cycles when the next idle cycle is the last allowed one.
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR_LO = 3'd1;
  localparam logic [2:0] S_ADDR_HI = 3'd2;
  localparam logic [2:0] S_LEN     = 3'd3;
  localparam logic [2:0] S_PAYLOAD = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;

  logic [2:0]    state;
  logic [15:0]   word_addr;
  logic [7:0]    word_cnt;
  logic [1:0]    byte_idx;
  logic [23:0]   data_acc;
  logic [7:0]    sum;
  logic [7:0]    sum_next;
  logic [TW-1:0] idle_cnt;
  logic          timeout_hit;

  assign busy_out    = (state != S_IDLE);
  assign sum_next    = sum + byte_in;
  // A byte arriving on the expiring cycle wins over the timeout.
  assign timeout_hit = busy_out && !valid_in && (idle_cnt == TLIM);

  // Idle-gap counter: cleared by any byte or while idle, counts cycles otherwise.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      idle_cnt <= '0;
    end else if (valid_in || !busy_out || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  // Frame state machine, word assembly, checksum and output strobes.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= S_IDLE;
      word_addr       <= 16'h0000;
      word_cnt        <= 8'h00;
      byte_idx        <= 2'd0;
      data_acc        <= 24'h0;
      sum             <= 8'h00;
      valid_out       <= 1'b0;
      addr_out        <= 16'h0000;
      data_out        <= 32'h0;
      frame_done_out  <= 1'b0;
      frame_error_out <= 1'b0;
    end else begin
      valid_out       <= 1'b0;
      frame_done_out  <= 1'b0;
      frame_error_out <= 1'b0;
      if (valid_in) begin
        case (state)
          S_IDLE: begin
            if (byte_in == SYNC_BYTE) begin
              state    <= S_ADDR_LO;
              sum      <= 8'h00;
              byte_idx <= 2'd0;
              data_acc <= 24'h0;
            end
          end
          S_ADDR_LO: begin
            word_addr[7:0] <= byte_in;
            sum            <= sum_next;
            state          <= S_ADDR_HI;
          end
          S_ADDR_HI: begin
            word_addr[15:8] <= byte_in;
            sum             <= sum_next;
            state           <= S_LEN;
          end
          S_LEN: begin
            sum <= sum_next;
            if (byte_in == 8'h00) begin
              state <= S_CHECK;
            end else begin
              word_cnt <= byte_in;
              byte_idx <= 2'd0;
              state    <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            sum      <= sum_next;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0:    data_acc[7:0]   <= byte_in;
              2'd1:    data_acc[15:8]  <= byte_in;
              2'd2:    data_acc[23:16] <= byte_in;
              default: begin
                // Words go out immediately; a later checksum error invalidates them downstream.
                data_out  <= {byte_in, data_acc};
                addr_out  <= word_addr;
                valid_out <= 1'b1;
                word_addr <= word_addr + 16'd1;
                word_cnt  <= word_cnt - 8'd1;
                if (word_cnt == 8'd1) begin
                  state <= S_CHECK;
                end
              end
            endcase
          end
          S_CHECK: begin
            // Any byte here is the checksum, including one equal to SYNC_BYTE.
            if (sum_next == 8'h00) begin
              frame_done_out <= 1'b1;
            end else begin
              frame_error_out <= 1'b1;
            end
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end else if (timeout_hit) begin
        // Abandon the frame; any partially assembled word is dropped.
        frame_error_out <= 1'b1;
        state           <= S_IDLE;
        byte_idx        <= 2'd0;
        data_acc        <= 24'h0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Bench for uart_frame_decoder: directed frames, timeout, reset, then random frames.
// Expected words and frame outcomes come from a frame-level model built from the byte format.
// A negedge monitor collects all DUT strobes into queues and counters.
module tb_uart_frame_decoder;

  localparam int         T    = 40;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        valid_in = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        valid_out;
  logic [15:0] addr_out;
  logic [31:0] data_out;
  logic        frame_done_out;
  logic        frame_error_out;
  logic        busy_out;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [47:0] got_q[$];
  logic [47:0] exp_q[$];
  logic [7:0]  bq[$];
  logic [7:0]  pay[$];
  logic prev_v = 1'b0, prev_d = 1'b0, prev_e = 1'b0;

  uart_frame_decoder #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(T)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .byte_in(byte_in),
    .valid_out(valid_out), .addr_out(addr_out), .data_out(data_out),
    .frame_done_out(frame_done_out), .frame_error_out(frame_error_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: collect strobes, enforce single-cycle pulses and done/error exclusivity.
  always @(negedge clk_in) begin
    if (rst_in) begin
      prev_v <= 1'b0; prev_d <= 1'b0; prev_e <= 1'b0;
    end else begin
      if (valid_out) got_q.push_back({addr_out, data_out});
      if (frame_done_out) done_cnt <= done_cnt + 1;
      if (frame_error_out) err_cnt <= err_cnt + 1;
      if (frame_done_out && frame_error_out) check("done_err_same_cycle", 1, 0);
      if (prev_v && valid_out) check("valid_out_two_cycles", 1, 0);
      if (prev_d && frame_done_out) check("done_two_cycles", 1, 0);
      if (prev_e && frame_error_out) check("error_two_cycles", 1, 0);
      prev_v <= valid_out; prev_d <= frame_done_out; prev_e <= frame_error_out;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one byte; returns #1 after the edge that sampled it.
  task automatic send(input logic [7:0] b);
    valid_in = 1'b1;
    byte_in  = b;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  task automatic send_q(input int maxgap);
    for (int i = 0; i < bq.size(); i++) begin
      send(bq[i]);
      if (maxgap > 0) idle($urandom_range(0, maxgap));
    end
    bq.delete();
  endtask

  task automatic compare_words(input string tag);
    int n;
    check({tag, "_word_count"}, 48'(got_q.size()), 48'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_word"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // Frame model: appends the frame bytes built from `pay` to bq, pushes expected words.
  task automatic build_frame(input logic [15:0] a, input logic [7:0] len, input bit bad, output bit ok);
    int s;
    logic [7:0] chk;
    s = a[7:0] + a[15:8] + len;
    bq.push_back(SYNC); bq.push_back(a[7:0]); bq.push_back(a[15:8]); bq.push_back(len);
    for (int w = 0; w < len; w++) begin
      logic [15:0] wa;
      wa = a + 16'(w);
      exp_q.push_back({wa, pay[4*w+3], pay[4*w+2], pay[4*w+1], pay[4*w]});
      for (int k = 0; k < 4; k++) begin
        bq.push_back(pay[4*w+k]);
        s += pay[4*w+k];
      end
    end
    chk = 8'((256 - (s % 256)) % 256);
    if (bad) chk = chk + 8'($urandom_range(1, 255));
    bq.push_back(chk);
    ok = !bad;
    pay.delete();
  endtask

  initial begin
    int d0, e0, n;
    bit ok;

    // Reset state
    idle(3);
    check("rst_valid_out", valid_out, 0);
    check("rst_addr_out", addr_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_done", frame_done_out, 0);
    check("rst_error", frame_error_out, 0);
    check("rst_busy", busy_out, 0);
    rst_in = 1'b0;
    idle(1);

    // Normal frame with cycle-exact strobe timing
    d0 = done_cnt; e0 = err_cnt;
    send(8'hA5); send(8'h10); send(8'h00); send(8'h01);
    check("normal_busy", busy_out, 1);
    send(8'hEF); send(8'hBE); send(8'hAD);
    check("normal_no_early_valid", valid_out, 0);
    send(8'hDE);
    check("normal_valid", valid_out, 1);
    check("normal_addr", addr_out, 48'h0010);
    check("normal_data", data_out, 48'hDEADBEEF);
    check("normal_no_done_with_word", frame_done_out, 0);
    send(8'hB7);
    check("normal_valid_drop", valid_out, 0);
    check("normal_done", frame_done_out, 1);
    check("normal_no_err", frame_error_out, 0);
    idle(1);
    check("normal_done_drop", frame_done_out, 0);
    check("normal_idle", busy_out, 0);
    got_q.delete();

    // Bad checksum
    d0 = done_cnt; e0 = err_cnt;
    bq = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
    exp_q.push_back({16'h0010, 32'hDEADBEEF});
    send_q(0); idle(2);
    compare_words("badchk");
    check("badchk_err", 48'(err_cnt - e0), 1);
    check("badchk_done", 48'(done_cnt - d0), 0);

    // Noise then empty frame (checksum of three zero bytes is zero)
    d0 = done_cnt; e0 = err_cnt;
    bq = '{8'h3C, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    send_q(0); idle(2);
    compare_words("empty");
    check("empty_done", 48'(done_cnt - d0), 1);
    check("empty_err", 48'(err_cnt - e0), 0);

    // Address wrap: sum FF+FF+02+(11..18) = A4, CHK = 5C
    d0 = done_cnt; e0 = err_cnt;
    bq = '{8'hA5, 8'hFF, 8'hFF, 8'h02, 8'h11, 8'h12, 8'h13, 8'h14,
           8'h15, 8'h16, 8'h17, 8'h18, 8'h5C};
    exp_q.push_back({16'hFFFF, 32'h14131211});
    exp_q.push_back({16'h0000, 32'h18171615});
    send_q(0); idle(2);
    compare_words("wrap");
    check("wrap_done", 48'(done_cnt - d0), 1);
    check("wrap_err", 48'(err_cnt - e0), 0);

    // Timeout after SYNC, ADDR_LO; error after T idle cycles
    e0 = err_cnt;
    send(8'hA5); send(8'h10);
    n = 0;
    while (!frame_error_out && n < 3 * T) begin
      @(posedge clk_in); #1;
      n++;
    end
    check("timeout_cycles", 48'(n), 48'(T));
    check("timeout_busy", busy_out, 0);
    idle(2);
    check("timeout_one_pulse", 48'(err_cnt - e0), 1);
    check("timeout_no_word", 48'(got_q.size()), 0);
    d0 = done_cnt; e0 = err_cnt;
    bq = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB7};
    exp_q.push_back({16'h0010, 32'hDEADBEEF});
    send_q(0); idle(2);
    compare_words("after_timeout");
    check("after_timeout_done", 48'(done_cnt - d0), 1);
    check("after_timeout_err", 48'(err_cnt - e0), 0);

    // Bytes arriving exactly on the expiring cycle keep the frame alive
    d0 = done_cnt; e0 = err_cnt;
    bq = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB7};
    for (int i = 0; i < bq.size(); i++) begin
      send(bq[i]);
      if (i < bq.size() - 1) idle(T - 1);
    end
    bq.delete();
    exp_q.push_back({16'h0010, 32'hDEADBEEF});
    idle(2);
    compare_words("edge_gap");
    check("edge_gap_done", 48'(done_cnt - d0), 1);
    check("edge_gap_err", 48'(err_cnt - e0), 0);

    // Reset mid-payload: outputs clear asynchronously, no pulses, fresh SYNC needed
    d0 = done_cnt; e0 = err_cnt;
    send(8'hA5); send(8'h20); send(8'h00); send(8'h01); send(8'h11); send(8'h22);
    rst_in = 1'b1;
    #2;
    check("rst_mid_addr", addr_out, 0);
    check("rst_mid_data", data_out, 0);
    check("rst_mid_busy", busy_out, 0);
    check("rst_mid_valid", valid_out, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    bq = '{8'h33, 8'h44, 8'hB7};
    send_q(0);
    check("rst_mid_stays_idle", busy_out, 0);
    pay = '{8'h01, 8'h02, 8'h03, 8'h04};
    build_frame(16'h0020, 8'd1, 1'b0, ok);
    send_q(0); idle(2);
    compare_words("after_rst");
    check("after_rst_done", 48'(done_cnt - d0), 1);
    check("after_rst_err", 48'(err_cnt - e0), 0);

    // Random frames with noise, gaps, wrap-prone addresses and corrupted checksums
    for (int f = 0; f < 40; f++) begin
      logic [15:0] a;
      logic [7:0] len;
      bit bad;
      repeat ($urandom_range(0, 2)) begin
        logic [7:0] nb;
        nb = 8'($urandom_range(0, 255));
        if (nb == SYNC) nb = 8'h5A;
        bq.push_back(nb);
      end
      a   = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      len = 8'($urandom_range(0, 4));
      bad = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 4 * len; k++) pay.push_back(8'($urandom_range(0, 255)));
      d0 = done_cnt; e0 = err_cnt;
      build_frame(a, len, bad, ok);
      send_q(3); idle(2);
      compare_words("rand");
      check("rand_done", 48'(done_cnt - d0), ok ? 48'd1 : 48'd0);
      check("rand_err", 48'(err_cnt - e0), ok ? 48'd0 : 48'd1);
    end
    check("final_idle", busy_out, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
